dmux_nway_buf: RTL and testbench
================================

// Module: dmux_nway_buf
// PURPOSE
//  Parametrised 1-to-NOUT demultiplexer with valid/ready handshake and a
//  one-entry output buffer per channel. Routes each accepted input word to
//  the channel selected by in_sel, one cycle later. Successor to the
//  combinational 8-way demux for datapaths that need back-pressure.
// PARAMETERS
//  WIDTH  8  data word width in bits
//  NOUT   8  number of output channels (2..64; need not be a power of 2)
//  SELW   3  in_sel width; must satisfy 2**SELW >= NOUT
//  CNTW   16 width of accept counter (wraps)
// PORTS
//  clk         in   1           single clock, rising edge
//  reset       in   1           synchronous, active-high
//  in_data     in   WIDTH       input word
//  in_sel      in   SELW        destination channel index
//  in_valid    in   1           input word valid
//  in_ready    out  1           block can accept word this cycle
//  out_data    out  NOUT*WIDTH  channel k at [k*WIDTH +: WIDTH]
//  out_valid   out  NOUT        per-channel valid
//  out_ready   in   NOUT        per-channel consumer ready
//  sel_err     out  1           1-cycle pulse: word accepted with in_sel>=NOUT
//  accept_cnt  out  CNTW        count of words delivered into a slot
//  in_bcast    in   1           (DMUX_BCAST_EN only) broadcast request
// BEHAVIOUR
//  - Reset (clk edge with reset=1): out_valid=0, out_data=0, sel_err=0,
//    accept_cnt=0; in_ready=0 while reset high; buffered words discarded.
//  - Slot k state: EMPTY / FULL. pop_k = out_valid[k] & out_ready[k].
//  - in_ready (comb) = !reset & (in_sel>=NOUT | !out_valid[in_sel] | pop_sel).
//  - Accept = in_valid & in_ready. Latency 1: word on out_data[k] with
//    out_valid[k]=1 at the next edge. Full throughput: push+pop same cycle
//    on one slot replaces content, slot stays FULL.
//  - out_data[k] stable while out_valid[k] & !out_ready[k]; other slots
//    unaffected by traffic to k. Slots drain independently.
//  - in_sel>=NOUT: word accepted and dropped, sel_err=1 for exactly the
//    next cycle, accept_cnt unchanged, no out_valid change.
//  - accept_cnt += 1 per routed accept; wraps 2**CNTW-1 -> 0.
//  - in_valid=0: no state change except pops; in_data/in_sel ignored.
//  - out_data of an EMPTY slot holds last value (don't care for checkers).
// CONFIGURATION
//  DMUX_BCAST_EN defined: in_bcast=1 with in_valid copies word to all NOUT
//   slots; in_ready = all slots EMPTY-or-popping; in_sel ignored, no
//   sel_err; accept_cnt += 1. in_bcast=0 behaves as unicast.
//  Not defined: port in_bcast absent; unicast only, as above.
// STRUCTURE
//  - Header dmux_defs.vh: slot state encodings (SLOT_EMPTY=0, SLOT_FULL=1),
//    default WIDTH/NOUT/SELW/CNTW constants, clog2 helper macro.
//  - Sub-module dmux_slot: one-entry buffer (WIDTH, push, data, pop ->
//    valid, data, can_push); instantiated NOUT times via generate.
//  - Top holds sel decode, in_ready mux, sel_err register, accept_cnt.
// TESTING (WIDTH=8, NOUT=6, SELW=3, CNTW=4)
//  1 reset; sweep in_sel 0..5, in_data=8'hA0+k, out_ready=all 1 -> each
//    out_valid[k] one cycle after accept, data 8'hA0+k, others 0.
//  2 out_ready[2]=0, send two words 8'h11,8'h22 to ch2 -> 2nd held
//    (in_ready=0), out_data[2]=8'h11 stable; raise out_ready[2] -> 8'h22
//    lands next cycle, no loss or duplicate.
//  3 ch2 FULL and stalled; send 8'h33 to ch4 -> accepted, ch4 valid next
//    cycle, ch2 unchanged.
//  4 in_sel=6 and 7 -> in_ready=1, sel_err pulses 1 cycle each,
//    accept_cnt unchanged, out_valid unchanged.
//  5 17 routed accepts with continuous drain -> accept_cnt=4'h1 (wrap);
//    reset asserted with slots FULL -> next cycle out_valid=0, cnt=0.
//  6 DMUX_BCAST_EN: in_bcast=1, data 8'h5A, all ready -> all six
//    out_valid=1 with 8'h5A; one slot stalled -> in_ready=0 until it pops.

Source files
------------

// File: rtl/dmux_nway_buf_pkg.sv
// Shared types and default parameters for the dmux_nway_buf slice.
// Optional broadcast mode is selected with the DMUX_BCAST_EN macro.
package dmux_nway_buf_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NOUT  = 8;
    localparam int DEF_SELW  = 3;
    localparam int DEF_CNTW  = 16;

    // Minimum index width for n entries, never below one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dmux_nway_buf_slot.sv
// One-entry output buffer for a single demux channel.
// A push in the same cycle as a pop replaces the word and keeps the slot full.
module dmux_nway_buf_slot
    import dmux_nway_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_push
);

    slot_state_e state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else if (push && can_push) begin
            state <= SLOT_FULL;
            data  <= push_data;
        end else if (pop) begin
            state <= SLOT_EMPTY;
        end
    end

    assign valid    = (state == SLOT_FULL);
    assign can_push = !valid || pop;

endmodule

// File: rtl/dmux_nway_buf.sv
// 1-to-NOUT demultiplexer with valid/ready handshake and a one-entry buffer per channel.
// Define DMUX_BCAST_EN to add the in_bcast port for copying a word to every channel.
module dmux_nway_buf
    import dmux_nway_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NOUT  = DEF_NOUT,
    parameter int SELW  = DEF_SELW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef DMUX_BCAST_EN
    input  logic                  in_bcast,
`endif
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic                  sel_err,
    output logic [CNTW-1:0]       accept_cnt
);

    localparam logic [SELW:0] NOUT_L = (SELW + 1)'(NOUT);

    logic            bcast;
    logic            sel_ok;
    logic            sel_can;
    logic            accept;
    logic [NOUT-1:0] can_push;
    logic [NOUT-1:0] push;
    logic [NOUT-1:0] pop;

`ifdef DMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = ({1'b0, in_sel} < NOUT_L);

    // Out-of-range selects never index can_push; they are always acceptable.
    always_comb begin
        sel_can = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            if (in_sel == SELW'(k)) sel_can = can_push[k];
        end
    end

    assign in_ready = !reset && (bcast ? (&can_push) : (!sel_ok || sel_can));
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        assign pop[k]  = out_valid[k] && out_ready[k];
        assign push[k] = accept && (bcast || (sel_ok && (in_sel == SELW'(k))));

        dmux_nway_buf_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .push      (push[k]),
            .push_data (in_data),
            .pop       (pop[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH]),
            .can_push  (can_push[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err    <= 1'b0;
            accept_cnt <= '0;
        end else begin
            sel_err <= accept && !bcast && !sel_ok;
            if (accept && (bcast || sel_ok)) accept_cnt <= accept_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmux_nway_buf.sv
// Self-checking bench for dmux_nway_buf (WIDTH=8, NOUT=6, SELW=3, CNTW=4).
// Broadcast scenarios are included when DMUX_BCAST_EN is defined.
module tb_dmux_nway_buf;

    localparam int WIDTH = 8;
    localparam int NOUT  = 6;
    localparam int SELW  = 3;
    localparam int CNTW  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WIDTH-1:0]      in_data;
    logic [SELW-1:0]       in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic                  sel_err;
    logic [CNTW-1:0]       accept_cnt;
    logic                  in_bcast;

    always #5 clk = ~clk;

    dmux_nway_buf #(.WIDTH(WIDTH), .NOUT(NOUT), .SELW(SELW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DMUX_BCAST_EN
        .in_bcast   (in_bcast),
`endif
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel_err    (sel_err),
        .accept_cnt (accept_cnt)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: per-channel occupancy and content, counter, error pulse.
    logic       mv [NOUT];
    logic [7:0] md [NOUT];
    int         mcnt;
    logic       merr;
    logic       exp_rdy;
    logic       obs_rdy;

    function automatic logic [NOUT-1:0] mv_vec();
        logic [NOUT-1:0] v;
        for (int k = 0; k < NOUT; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic logic [7:0] slot_data(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NOUT; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        mcnt = 0;
        merr = 1'b0;
    endtask

    // Leaves reset asserted at a falling edge; caller releases it.
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [2:0] sel, input logic [7:0] d,
                        input logic [NOUT-1:0] ordy, input logic bc);
        logic acc;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        in_bcast  = bc;
        #1;
        obs_rdy = in_ready;
        if (bc) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < NOUT; k++) exp_rdy = exp_rdy && (!mv[k] || ordy[k]);
        end else if (sel >= NOUT) begin
            exp_rdy = 1'b1;
        end else begin
            exp_rdy = !mv[sel] || ordy[sel];
        end
        acc = v && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < NOUT; k++) if (mv[k] && ordy[k]) mv[k] = 1'b0;
        merr = acc && !bc && (sel >= NOUT);
        if (acc && (bc || sel < NOUT)) begin
            mcnt = (mcnt + 1) % (1 << CNTW);
            for (int k = 0; k < NOUT; k++) begin
                if (bc || k == int'(sel)) begin
                    mv[k] = 1'b1;
                    md[k] = d;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 6'b0) $display("FAIL reset_out_valid got %b want 000000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (accept_cnt !== 4'h0 || sel_err !== 1'b0)
            $display("FAIL reset_cnt_err got cnt=%h err=%b want cnt=0 err=0", accept_cnt, sel_err);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 48'h0) $display("FAIL reset_out_data got %h want 0", out_data);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        for (int k = 0; k < NOUT; k++) begin
            step(1'b1, 3'(k), 8'hA0 + 8'(k), 6'b111111, 1'b0);
            total_cnt++;
            if (out_valid !== 6'(1 << k) || slot_data(k) !== 8'hA0 + 8'(k))
                $display("FAIL sweep_ch%0d got valid=%b data=%h want valid=%b data=%h",
                         k, out_valid, slot_data(k), 6'(1 << k), 8'hA0 + 8'(k));
            else pass_cnt++;
        end
        total_cnt++;
        if (accept_cnt !== 4'd6) $display("FAIL sweep_cnt got %0d want 6", accept_cnt);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int c0;
        c0 = mcnt;
        step(1'b1, 3'd2, 8'h11, 6'b111011, 1'b0);
        total_cnt++;
        if (obs_rdy !== 1'b1 || out_valid[2] !== 1'b1 || slot_data(2) !== 8'h11)
            $display("FAIL stall_first got rdy=%b v2=%b d2=%h want 1 1 11", obs_rdy, out_valid[2], slot_data(2));
        else pass_cnt++;
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 3'd2, 8'h22, 6'b111011, 1'b0);
            total_cnt++;
            if (obs_rdy !== 1'b0 || out_valid[2] !== 1'b1 || slot_data(2) !== 8'h11)
                $display("FAIL stall_hold%0d got rdy=%b v2=%b d2=%h want 0 1 11", r, obs_rdy, out_valid[2], slot_data(2));
            else pass_cnt++;
        end
        step(1'b1, 3'd2, 8'h22, 6'b111111, 1'b0);
        total_cnt++;
        if (obs_rdy !== 1'b1 || out_valid[2] !== 1'b1 || slot_data(2) !== 8'h22)
            $display("FAIL stall_release got rdy=%b v2=%b d2=%h want 1 1 22", obs_rdy, out_valid[2], slot_data(2));
        else pass_cnt++;
        total_cnt++;
        if (accept_cnt !== 4'((c0 + 2) % 16))
            $display("FAIL stall_count got %0d want %0d", accept_cnt, (c0 + 2) % 16);
        else pass_cnt++;
    endtask

    task automatic test_other_channel();
        step(1'b1, 3'd4, 8'h33, 6'b111011, 1'b0);
        total_cnt++;
        if (obs_rdy !== 1'b1 || out_valid[4] !== 1'b1 || slot_data(4) !== 8'h33)
            $display("FAIL other_ch4 got rdy=%b v4=%b d4=%h want 1 1 33", obs_rdy, out_valid[4], slot_data(4));
        else pass_cnt++;
        total_cnt++;
        if (out_valid[2] !== 1'b1 || slot_data(2) !== 8'h22)
            $display("FAIL other_ch2 got v2=%b d2=%h want 1 22", out_valid[2], slot_data(2));
        else pass_cnt++;
    endtask

    task automatic test_bad_sel();
        logic [NOUT-1:0] ov0;
        int c0;
        for (int s = 6; s <= 7; s++) begin
            ov0 = mv_vec();
            c0  = mcnt;
            step(1'b1, 3'(s), 8'hEE, 6'b000000, 1'b0);
            total_cnt++;
            if (obs_rdy !== 1'b1 || sel_err !== 1'b1)
                $display("FAIL badsel%0d_pulse got rdy=%b err=%b want 1 1", s, obs_rdy, sel_err);
            else pass_cnt++;
            total_cnt++;
            if (accept_cnt !== 4'(c0) || out_valid !== ov0)
                $display("FAIL badsel%0d_state got cnt=%0d valid=%b want %0d %b", s, accept_cnt, out_valid, c0, ov0);
            else pass_cnt++;
            step(1'b0, 3'd0, 8'h00, 6'b000000, 1'b0);
            total_cnt++;
            if (sel_err !== 1'b0) $display("FAIL badsel%0d_width got err=%b want 0", s, sel_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) step(1'b1, 3'(i % NOUT), 8'(i), 6'b111111, 1'b0);
        total_cnt++;
        if (accept_cnt !== 4'h1) $display("FAIL wrap_cnt got %h want 1", accept_cnt);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) step(1'b1, 3'(k), 8'h70 + 8'(k), 6'b000000, 1'b0);
        total_cnt++;
        if (out_valid[2:0] !== 3'b111) $display("FAIL wrap_fill got %b want 111", out_valid[2:0]);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (out_valid !== 6'b0 || accept_cnt !== 4'h0)
            $display("FAIL reset_full got valid=%b cnt=%h want 000000 0", out_valid, accept_cnt);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic            v;
        logic [2:0]      sel;
        logic [NOUT-1:0] ordy;
        logic            bc;
        int              bad;
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            sel  = 3'($urandom_range(0, 7));
            ordy = 6'($urandom) | 6'($urandom);
            if ($urandom_range(0, 4) == 0) ordy = '0;
            bc = 1'b0;
`ifdef DMUX_BCAST_EN
            bc = ($urandom_range(0, 7) == 0);
`endif
            step(v, sel, 8'($urandom), ordy, bc);
            total_cnt++;
            if (obs_rdy !== exp_rdy) $display("FAIL rand_in_ready cyc=%0d got %b want %b", i, obs_rdy, exp_rdy);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== mv_vec()) $display("FAIL rand_out_valid cyc=%0d got %b want %b", i, out_valid, mv_vec());
            else pass_cnt++;
            bad = -1;
            for (int k = 0; k < NOUT; k++) if (mv[k] && slot_data(k) !== md[k]) bad = k;
            total_cnt++;
            if (bad >= 0) $display("FAIL rand_data cyc=%0d ch=%0d got %h want %h", i, bad, slot_data(bad), md[bad]);
            else pass_cnt++;
            total_cnt++;
            if (sel_err !== merr || accept_cnt !== 4'(mcnt))
                $display("FAIL rand_err_cnt cyc=%0d got err=%b cnt=%0d want %b %0d", i, sel_err, accept_cnt, merr, mcnt);
            else pass_cnt++;
        end
    endtask

`ifdef DMUX_BCAST_EN
    task automatic test_bcast();
        logic ok;
        do_reset();
        reset = 1'b0;
        step(1'b1, 3'd7, 8'h5A, 6'b111111, 1'b1);
        ok = (out_valid === 6'b111111);
        for (int k = 0; k < NOUT; k++) if (slot_data(k) !== 8'h5A) ok = 1'b0;
        total_cnt++;
        if (!ok || sel_err !== 1'b0 || accept_cnt !== 4'h1)
            $display("FAIL bcast_all got valid=%b err=%b cnt=%h want 111111 0 1", out_valid, sel_err, accept_cnt);
        else pass_cnt++;
        step(1'b1, 3'd0, 8'h66, 6'b111110, 1'b1);
        total_cnt++;
        if (obs_rdy !== 1'b0 || slot_data(0) !== 8'h5A)
            $display("FAIL bcast_stall got rdy=%b d0=%h want 0 5a", obs_rdy, slot_data(0));
        else pass_cnt++;
        step(1'b1, 3'd0, 8'h66, 6'b111111, 1'b1);
        ok = (out_valid === 6'b111111);
        for (int k = 0; k < NOUT; k++) if (slot_data(k) !== 8'h66) ok = 1'b0;
        total_cnt++;
        if (obs_rdy !== 1'b1 || !ok || accept_cnt !== 4'h2)
            $display("FAIL bcast_release got rdy=%b valid=%b cnt=%h want 1 111111 2", obs_rdy, out_valid, accept_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        test_reset();
        test_sweep();
        test_stall();
        test_other_channel();
        test_bad_sel();
        test_wrap_reset();
        test_random();
`ifdef DMUX_BCAST_EN
        test_bcast();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
